// File: rtl/jericalla_pkg.sv
// Shared op-code constants and sequencer state encoding for the jericalla block.
package jericalla_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/jericalla_alu.sv
// Combinational ALU; unknown op codes produce zero.
module jericalla_alu
  import jericalla_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y_c
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    y_c = '0;
    case (op)
      OP_ADD:  y_c = a + b;
      OP_SUB:  y_c = a - b;
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_SLL:  y_c = a << shamt;
      OP_SRL:  y_c = a >> shamt;
      OP_SLT:  y_c = DATA_W'($signed(a) < $signed(b));
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/jericalla_seq.sv
// Four-phase command sequencer: read two registers, run the ALU, write the
// result back to the register file or the RAM.
module jericalla_seq
  import jericalla_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic              cmd_wb_rf,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t state, state_n;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
  logic              wb_rf_q;
  logic [DATA_W-1:0] a_q, b_q, alu_y;
  logic              accept;

  logic [DATA_W-1:0] rf  [DEPTH];
  logic [DATA_W-1:0] ram [DEPTH];

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_READ;
      ST_READ:  state_n = ST_EXEC;
      ST_EXEC:  state_n = ST_WRITE;
      ST_WRITE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Status flags track the state being entered so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmd_ready <= (state_n == ST_IDLE);
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_WRITE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      wb_rf_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      result  <= '0;
      zf      <= 1'b1;
    end else begin
      if (state == ST_IDLE && accept) begin
        op_q    <= cmd_op;
        src1_q  <= cmd_src1;
        src2_q  <= cmd_src2;
        dst_q   <= cmd_dst;
        wb_rf_q <= cmd_wb_rf;
      end
      if (state == ST_READ) begin
        a_q <= rf[src1_q];
        b_q <= rf[src2_q];
      end
      if (state == ST_EXEC) begin
        result <= alu_y;
        zf     <= (alu_y == '0);
      end
    end
  end

  jericalla_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y_c (alu_y)
  );

  // The load port is applied last so it overrides a same-address writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf <= '{default: '0};
    end else begin
      if (state == ST_WRITE && wb_rf_q) rf[dst_q] <= result;
      if (ld_en) rf[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram     <= '{default: '0};
      rd_data <= '0;
    end else begin
      if (state == ST_WRITE && !wb_rf_q) ram[dst_q] <= result;
      rd_data <= ram[rd_addr];
    end
  end

endmodule

// File: tb/tb_jericalla_seq.sv
// Randomised and directed bench for jericalla_seq against a phase-based
// behavioural model of command execution.
module tb_jericalla_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_src1, cmd_src2, cmd_dst;
  logic          cmd_wb_rf;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy, done, zf;
  logic [DW-1:0] result;

  jericalla_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .cmd_wb_rf(cmd_wb_rf),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .result(result), .zf(zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit last_hs;

  // Model: age counts cycles since acceptance (0 = no command in flight).
  logic [DW-1:0] m_rf  [DEPTH];
  logic [DW-1:0] m_ram [DEPTH];
  int            m_age;
  logic [3:0]    m_op;
  logic [AW-1:0] m_s1, m_s2, m_dst;
  bit            m_wb;
  logic [DW-1:0] m_a, m_b, m_res;
  bit            e_ready, e_busy, e_done, e_zf;
  logic [DW-1:0] e_result, e_rd;

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int unsigned sh;
    sh = int'(b) % DW;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i]  = '0;
      m_ram[i] = '0;
    end
    m_age = 0; m_res = '0; m_a = '0; m_b = '0;
    e_ready = 0; e_busy = 0; e_done = 0; e_zf = 1; e_result = '0; e_rd = '0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] rd_next;
    int age_n;
    if (rst) begin
      model_reset();
      return;
    end
    rd_next = m_ram[rd_addr];
    age_n = m_age;
    case (m_age)
      0: if (cmd_valid && e_ready) begin
           m_op = cmd_op; m_s1 = cmd_src1; m_s2 = cmd_src2; m_dst = cmd_dst; m_wb = cmd_wb_rf;
           age_n = 1;
         end
      1: begin m_a = m_rf[m_s1]; m_b = m_rf[m_s2]; age_n = 2; end
      2: begin m_res = ref_alu(m_op, m_a, m_b); age_n = 3; end
      default: begin
        if (m_wb) m_rf[m_dst] = m_res;
        else      m_ram[m_dst] = m_res;
        age_n = 0;
      end
    endcase
    if (ld_en) m_rf[ld_addr] = ld_data;
    m_age    = age_n;
    e_ready  = (age_n == 0);
    e_busy   = (age_n != 0);
    e_done   = (age_n == 3);
    e_result = m_res;
    e_zf     = (m_res == '0);
    e_rd     = rd_next;
  endtask

  task automatic compare();
    check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    check("busy",      32'(busy),      32'(e_busy));
    check("done",      32'(done),      32'(e_done));
    check("result",    result,         e_result);
    check("zf",        32'(zf),        32'(e_zf));
    check("rd_data",   rd_data,        e_rd);
  endtask

  task automatic step();
    last_hs = cmd_valid && cmd_ready;
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic readback(input int a);
    rd_addr = AW'(a);
    step();
  endtask

  task automatic issue(input logic [3:0] op, input int s1, input int s2, input int dst, input bit wb,
                       input bit ld_w, input int la, input logic [DW-1:0] ld_d, output int done_at);
    cmd_op = op; cmd_src1 = AW'(s1); cmd_src2 = AW'(s2); cmd_dst = AW'(dst); cmd_wb_rf = wb;
    cmd_valid = 1'b1;
    done_at = -1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && ld_w) begin
        ld_en = 1'b1; ld_addr = AW'(la); ld_data = ld_d;
      end
      step();
      cmd_valid = 1'b0;
      ld_en = 1'b0;
      if (done && done_at < 0) done_at = k + 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dat;
    int acc;
    int idx [4];

    rst = 1'b1; cmd_valid = 0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0;
    cmd_wb_rf = 0; ld_en = 0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    model_reset();
    step();
    step();
    check("reset_ready", 32'(cmd_ready), 32'd0);
    check("reset_zf", 32'(zf), 32'd1);
    rst = 1'b0;
    step();
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // AND result written to RAM
    load(4, 32'h0000_00F0);
    load(6, 32'h0000_0FF0);
    issue(4'b0010, 4, 6, 3, 0, 0, 0, '0, dat);
    check("and_done_cycle", 32'(dat), 32'd3);
    check("and_result", result, 32'h0000_00F0);
    check("and_zf", 32'(zf), 32'd0);
    readback(3);
    check("and_ram3", rd_data, 32'h0000_00F0);

    // ADD wrap to zero, then use rf[5] and check SLT
    load(1, 32'hFFFF_FFFF);
    load(2, 32'h0000_0001);
    issue(4'b0000, 1, 2, 5, 1, 0, 0, '0, dat);
    check("add_wrap_result", result, 32'h0);
    check("add_wrap_zf", 32'(zf), 32'd1);
    issue(4'b0000, 5, 2, 0, 0, 0, 0, '0, dat);
    check("rf5_zero_plus_one", result, 32'h1);
    issue(4'b0111, 1, 2, 6, 1, 0, 0, '0, dat);
    check("slt_result", result, 32'h1);

    // Load beats writeback to the same register
    load(8, 32'h0000_0011);
    issue(4'b0011, 8, 8, 7, 1, 1, 7, 32'h0000_0022, dat);
    check("collide_wb_result", result, 32'h11);
    issue(4'b0011, 7, 7, 10, 0, 0, 0, '0, dat);
    check("collide_rf7", result, 32'h22);

    // Illegal op still writes zero
    issue(4'b0011, 4, 4, 12, 0, 0, 0, '0, dat);
    readback(12);
    check("ram12_before", rd_data, 32'h0000_00F0);
    issue(4'b1111, 4, 6, 12, 0, 0, 0, '0, dat);
    check("illegal_result", result, 32'h0);
    check("illegal_zf", 32'(zf), 32'd1);
    readback(12);
    check("illegal_ram12", rd_data, 32'h0);

    // Back-pressure: valid held for 10 cycles
    acc = 0;
    cmd_op = 4'b0000; cmd_src1 = 4'd1; cmd_src2 = 4'd2; cmd_dst = 4'd0; cmd_wb_rf = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      step();
      if (last_hs) begin
        if (acc < 4) idx[acc] = i;
        acc++;
      end
    end
    cmd_valid = 1'b0;
    check("bp_accept_count", 32'(acc), 32'd3);
    if (acc >= 3) begin
      check("bp_spacing_1", 32'(idx[1] - idx[0]), 32'd4);
      check("bp_spacing_2", 32'(idx[2] - idx[1]), 32'd4);
    end
    for (int i = 0; i < 4; i++) step();

    // Random traffic
    for (int i = 0; i < 240; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 4'($urandom_range(0, 9));
      cmd_src1  = AW'($urandom);
      cmd_src2  = AW'($urandom);
      cmd_dst   = AW'($urandom);
      cmd_wb_rf = 1'($urandom);
      ld_en     = ($urandom_range(0, 3) == 0);
      ld_addr   = AW'($urandom);
      ld_data   = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      rd_addr   = AW'($urandom);
      step();
    end
    cmd_valid = 1'b0; ld_en = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset during EXEC of a RAM write to 9
    load(3, 32'h0000_0007);
    cmd_op = 4'b0000; cmd_src1 = 4'd3; cmd_src2 = 4'd3; cmd_dst = 4'd9; cmd_wb_rf = 0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    step();
    rst = 1'b0;
    step();
    check("abort_ready_after_release", 32'(cmd_ready), 32'd1);
    check("abort_result", result, 32'h0);
    check("abort_zf", 32'(zf), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    readback(9);
    check("abort_ram9", rd_data, 32'h0);
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/jericalla_seq.md
JERICALLA_SEQ -- requirements
Module: jericalla_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of operands, results and memory words.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; register file and RAM each hold 2**ADDR_W words.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-006 SHALL have port cmd_op, input, 4: ALU operation code.
REQ-007 SHALL have ports cmd_src1, cmd_src2, cmd_dst, each input, ADDR_W: operand read addresses and destination address.
REQ-008 SHALL have port cmd_wb_rf, input, 1: 1 = write result to register file, 0 = write result to RAM.
REQ-009 SHALL have ports ld_en (input, 1), ld_addr (input, ADDR_W) and ld_data (input, DATA_W): register-file load port.
REQ-010 SHALL have ports rd_addr (input, ADDR_W) and rd_data (output, DATA_W): RAM readback port.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse marking writeback of a command.
REQ-013 SHALL have ports result (output, DATA_W) and zf (output, 1): last computed result and its zero flag.

Function
REQ-014 SHALL implement the FSM IDLE -> READ -> EXEC -> WRITE -> IDLE, advancing unconditionally except in IDLE.
REQ-015 SHALL assert cmd_ready only in IDLE, and SHALL accept a command on a cycle with cmd_valid & cmd_ready; acceptance latches op, src1, src2, dst and wb_rf, and the state moves to READ.
REQ-016 SHALL latch rf[src1] and rf[src2] in READ, using register-file contents as they stood before that edge's load.
REQ-017 SHALL compute the ALU result in EXEC and register it into result and zf; zf = (result == 0).
REQ-018 SHALL use these op codes: 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLL a by b[log2(DATA_W)-1:0]; 0110 SRL, same shift amount; 0111 SLT signed (result 1 or 0); all other codes yield 0.
REQ-019 SHALL wrap ADD and SUB modulo 2**DATA_W, with no carry or overflow output.
REQ-020 SHALL, in WRITE, write result to rf[dst] if wb_rf = 1, otherwise to ram[dst], and SHALL assert done for exactly that cycle.
REQ-021 SHALL give a command accepted at edge T done high during cycle T+3, with the write visible from edge T+4 onward; throughput is one command per 4 cycles.
REQ-022 SHALL honour ld_en in every state; if ld_en and a WRITE-state register-file writeback hit the same address in the same cycle, ld_data wins.
REQ-023 SHALL register rd_data as ram[rd_addr] with 1-cycle latency; a same-cycle RAM write to rd_addr returns the old value.
REQ-024 SHALL hold result and zf stable between EXEC updates.

Reset
REQ-025 SHALL, while rst is high, force state IDLE, cmd_ready 0, busy 0, done 0, result 0, zf 1, rd_data 0, and every register-file and RAM word to 0.
REQ-026 SHALL abort an in-flight command when rst is asserted mid-operation, with no writeback and no done pulse.
REQ-027 SHALL assert cmd_ready in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place op-code constants and the FSM state enumeration in shared package jericalla_pkg.
REQ-029 SHALL implement the ALU as a purely combinational sub-module jericalla_alu, parametrised by DATA_W and driven by op, a and b.

Verification
REQ-030 SHALL verify the AND-to-RAM path: load rf[4]=0x0000_00F0 and rf[6]=0x0000_0FF0, then issue op=0010, src1=4, src2=6, dst=3, wb_rf=0 -> done 3 cycles after acceptance, result=0x0000_00F0, zf=0, and rd_addr=3 then returns 0x0000_00F0.
REQ-031 SHALL verify wrap and zero flag: with rf[1]=0xFFFF_FFFF and rf[2]=1, op=0000 ADD, dst=5, wb_rf=1 -> result 0, zf=1, rf[5]=0; then op=0111 SLT on rf[1], rf[2] -> result 1.
REQ-032 SHALL verify back-pressure: hold cmd_valid high for 10 cycles -> cmd_ready high only in IDLE, exactly 3 commands accepted at 4-cycle spacing, and busy high in all non-IDLE cycles.
REQ-033 SHALL verify load/writeback collision: writeback to rf[7] with result 0x11 and ld_en to address 7 with 0x22 in the WRITE cycle -> rf[7]=0x22.
REQ-034 SHALL verify reset mid-operation: assert rst during EXEC of a RAM write to dst=9 -> no done pulse, ram[9]=0, result=0, zf=1, and cmd_ready=1 in the first cycle after release.
REQ-035 SHALL verify an illegal op: op=1111 -> result 0, zf=1, and the write of 0 still performed.
